// File: rtl/rv32i_pkg.sv
// Shared fetch-stage types and constants for the rv32i core.
package rv32i_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// Two-entry fetch packet FIFO; head visible combinationally, write visible next cycle.
// Flush empties the FIFO but still accepts a same-cycle push as the sole new entry.
module fetch_skid_buffer
   import rv32i_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  fetch_pkt_t i_push_dat,
   input  logic       i_pop,
   input  logic       i_flush,
   output fetch_pkt_t o_head,
   output logic [1:0] o_count
);

   fetch_pkt_t r_mem [2];
   logic       r_rd;
   logic       r_wr;
   logic [1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd    <= 1'b0;
         r_wr    <= i_push;
         r_count <= {1'b0, i_push};
         if (i_push) r_mem[0] <= i_push_dat;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_push_dat;
            r_wr        <= ~r_wr;
         end
         if (i_pop) r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(i_push && !i_pop && !i_flush && r_count == 2'd2));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(i_pop && !i_flush && r_count == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// rv32i fetch stage: PC owner, 1-cycle ROM, returned word bypasses to decode when the skid buffer is empty.
// Optional RV32I_FETCH_MISALIGN_EN: misaligned redirect targets yield a fault packet and halt fetch.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int          ROM_LAT      = 1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_fault
);

   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   logic        r_inflight;

   logic        w_mis;
   logic        w_halt;
   logic [31:0] w_redir_pc;
   logic        w_deq;
   logic        w_issue;
   logic [2:0]  w_occ;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   fetch_pkt_t  w_push_dat;
   fetch_pkt_t  w_head;
   logic [1:0]  w_count;

`ifdef RV32I_FETCH_MISALIGN_EN
   logic r_halt;

   assign w_mis      = redirect & (redirect_pc[1:0] != 2'b00);
   assign w_redir_pc = redirect_pc;
   assign w_halt     = r_halt;

   // Halt persists until a redirect lands on an aligned target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_halt <= 1'b0;
      else if (redirect) r_halt <= w_mis;
   end
`else
   assign w_mis      = 1'b0;
   assign w_redir_pc = redirect_pc & ~32'h0000_0003;
   assign w_halt     = 1'b0;
`endif

   assign w_empty  = (w_count == 2'd0);
   assign if_valid = ~w_empty | r_inflight;
   assign w_deq    = if_valid & if_ready;
   assign w_pop    = w_deq & ~w_empty;

   // Occupancy after this cycle's dequeue must leave room for one more return.
   assign w_occ    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_deq};
   assign w_issue  = redirect ? ~w_mis : (~w_halt & (w_occ < 3'd2));
   assign rom_addr = redirect ? w_redir_pc : r_pc;

   // A return bypassed straight to decode and accepted is not stored.
   assign w_push = (r_inflight & ~redirect & ~(w_empty & if_ready)) | w_mis;

   always_comb begin
      w_push_dat = '{pc: r_inflight_pc, instr: rom_data, fault: 1'b0};
      if (w_mis) w_push_dat = '{pc: redirect_pc, instr: INSTR_NOP, fault: 1'b1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= RESET_VECTOR;
         r_inflight    <= 1'b0;
         r_inflight_pc <= 32'h0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= rom_addr;
            r_pc          <= rom_addr + 32'd4;
         end
      end
   end

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (redirect),
      .o_head     (w_head),
      .o_count    (w_count)
   );

   assign if_pc    = ~w_empty ? w_head.pc    : (r_inflight ? r_inflight_pc : 32'h0);
   assign if_instr = ~w_empty ? w_head.instr : (r_inflight ? rom_data : INSTR_NOP);
   assign if_fault = ~w_empty & w_head.fault;

   a_rom_lat: assert property (@(posedge clk) ROM_LAT == 1);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle ROM returning word index (addr>>2).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;
   logic [31:0] rom_q = 32'h0;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_fault    (if_fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom_addr;
   assign rom_data = rom_q >> 2;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench 2 time units into cycle 0 after release.
   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, 32'h13}) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b f=%b pc=%h instr=%h, want v=0 f=0 pc=0 instr=00000013",
                  if_valid, if_fault, if_pc, if_instr);
      end
      n_cmp++;
      if (rom_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rom_addr: got %h want 00000000", rom_addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      if_ready = 1'b1;
      #1;
      n_cmp++;
      if ({if_valid, rom_addr} !== {1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL stream_c0: got v=%b ra=%h want v=0 ra=0", if_valid, rom_addr);
      end
      for (int k = 1; k <= 8; k++) begin
         cyc(); #1;
         n_cmp++;
         if ({if_valid, if_fault, if_pc, if_instr, rom_addr} !==
             {1'b1, 1'b0, 32'(4*(k-1)), 32'(k-1), 32'(4*k)}) begin
            n_bad++;
            $display("FAIL stream_c%0d: got v=%b f=%b pc=%h instr=%h ra=%h want pc=%h instr=%h ra=%h",
                     k, if_valid, if_fault, if_pc, if_instr, rom_addr, 4*(k-1), k-1, 4*k);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] e_pc [11] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8,
                                 32'h8, 32'hC, 32'h10, 32'h14};
      logic [31:0] e_ra [11] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10, 32'h10,
                                 32'h10, 32'h14, 32'h18, 32'h1C};
      do_reset();
      if_ready = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         cyc();
         if_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
         #1;
         n_cmp++;
         if ({if_valid, if_pc, if_instr, rom_addr} !==
             {1'b1, e_pc[c-1], e_pc[c-1] >> 2, e_ra[c-1]}) begin
            n_bad++;
            $display("FAIL stall_c%0d: got v=%b pc=%h instr=%h ra=%h want pc=%h instr=%h ra=%h",
                     c, if_valid, if_pc, if_instr, rom_addr, e_pc[c-1], e_pc[c-1] >> 2, e_ra[c-1]);
         end
      end
   endtask

   task automatic test_redirect_buffered();
      do_reset();
      if_ready = 1'b1;
      cyc(); cyc();
      cyc(); if_ready = 1'b0;
      cyc(); cyc();
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      n_cmp++;
      if ({if_valid, if_pc, rom_addr} !== {1'b1, 32'h8, 32'h100}) begin
         n_bad++;
         $display("FAIL redir_buf_issue: got v=%b pc=%h ra=%h want v=1 pc=8 ra=100", if_valid, if_pc, rom_addr);
      end
      cyc(); redirect = 1'b0; #1;
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'h40}) begin
         n_bad++;
         $display("FAIL redir_buf_first: got v=%b pc=%h instr=%h want pc=100 instr=40", if_valid, if_pc, if_instr);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(); if_ready = 1'b1; #1;
         n_cmp++;
         if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(32'h100 + 4*k), 32'(32'h40 + k)}) begin
            n_bad++;
            $display("FAIL redir_buf_seq%0d: got v=%b pc=%h instr=%h want pc=%h", k, if_valid, if_pc, if_instr,
                     32'h100 + 4*k);
         end
      end
   endtask

   task automatic test_redirect_accept();
      logic        rdy  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        rd   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] rdpc [7] = '{32'h0, 32'h200, 32'h0, 32'h300, 32'h500, 32'h0, 32'h0};
      logic [31:0] e_pc [7] = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h300, 32'h500, 32'h504};
      int n4 = 0;
      do_reset();
      if_ready = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         if_ready = rdy[c-1]; redirect = rd[c-1]; redirect_pc = rdpc[c-1];
         #1;
         if (if_valid && if_ready && if_pc == 32'h4) n4++;
         n_cmp++;
         if ({if_valid, if_pc, if_instr} !== {1'b1, e_pc[c-1], e_pc[c-1] >> 2}) begin
            n_bad++;
            $display("FAIL redir_acc_c%0d: got v=%b pc=%h instr=%h want pc=%h", c, if_valid, if_pc, if_instr,
                     e_pc[c-1]);
         end
      end
      redirect = 1'b0;
      n_cmp++;
      if (n4 !== 1) begin
         n_bad++;
         $display("FAIL redir_acc_pc4_count: got %0d want 1", n4);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      #1;
      n_cmp++;
      if (rom_addr !== 32'hFFFF_FFF8) begin
         n_bad++;
         $display("FAIL wrap_issue: got ra=%h want fffffff8", rom_addr);
      end
      cyc(); redirect = 1'b0; #1;
      n_cmp++;
      if ({if_pc, if_instr, rom_addr} !== {32'hFFFF_FFF8, 32'h3FFF_FFFE, 32'hFFFF_FFFC}) begin
         n_bad++;
         $display("FAIL wrap_c1: got pc=%h instr=%h ra=%h want fffffff8 3ffffffe fffffffc", if_pc, if_instr, rom_addr);
      end
      cyc(); #1;
      n_cmp++;
      if ({if_valid, if_pc, if_instr, rom_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0}) begin
         n_bad++;
         $display("FAIL wrap_c2: got v=%b pc=%h instr=%h ra=%h want fffffffc 3fffffff 0", if_valid, if_pc, if_instr,
                  rom_addr);
      end
      cyc(); #1;
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0}) begin
         n_bad++;
         $display("FAIL wrap_c3: got v=%b pc=%h instr=%h want pc=0 instr=0", if_valid, if_pc, if_instr);
      end
   endtask

`ifdef RV32I_FETCH_MISALIGN_EN
   task automatic test_misalign();
      do_reset();
      if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
      cyc(); redirect = 1'b0; #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc, if_instr} !== {1'b1, 1'b1, 32'h102, 32'h13}) begin
         n_bad++;
         $display("FAIL misalign_pkt: got v=%b f=%b pc=%h instr=%h want v=1 f=1 pc=102 instr=13",
                  if_valid, if_fault, if_pc, if_instr);
      end
      for (int k = 0; k < 2; k++) begin
         cyc(); #1;
         n_cmp++;
         if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_halt%0d: got v=%b want 0", k, if_valid);
         end
      end
      cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
      n_cmp++;
      if (rom_addr !== 32'h200) begin
         n_bad++;
         $display("FAIL misalign_resume_ra: got %h want 00000200", rom_addr);
      end
      cyc(); redirect = 1'b0; #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc, if_instr} !== {1'b1, 1'b0, 32'h200, 32'h80}) begin
         n_bad++;
         $display("FAIL misalign_resume: got v=%b f=%b pc=%h instr=%h want 1 0 200 80",
                  if_valid, if_fault, if_pc, if_instr);
      end
   endtask
`else
   task automatic test_misalign();
      do_reset();
      if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
      #1;
      n_cmp++;
      if (rom_addr !== 32'h100) begin
         n_bad++;
         $display("FAIL misalign_forced_ra: got %h want 00000100", rom_addr);
      end
      cyc(); redirect = 1'b0; #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc, if_instr} !== {1'b1, 1'b0, 32'h100, 32'h40}) begin
         n_bad++;
         $display("FAIL misalign_forced_pkt: got v=%b f=%b pc=%h instr=%h want 1 0 100 40",
                  if_valid, if_fault, if_pc, if_instr);
      end
      cyc(); #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc} !== {1'b1, 1'b0, 32'h104}) begin
         n_bad++;
         $display("FAIL misalign_forced_next: got v=%b f=%b pc=%h want 1 0 104", if_valid, if_fault, if_pc);
      end
   endtask
`endif

   task automatic test_reset_midstream();
      do_reset();
      if_ready = 1'b1;
      cyc(); cyc(); cyc();
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({if_valid, if_fault, if_pc, if_instr, rom_addr} !== {1'b0, 1'b0, 32'h0, 32'h13, 32'h0}) begin
         n_bad++;
         $display("FAIL midreset_async: got v=%b f=%b pc=%h instr=%h ra=%h want 0 0 0 13 0",
                  if_valid, if_fault, if_pc, if_instr, rom_addr);
      end
      cyc(); reset = 1'b0; #1;
      n_cmp++;
      if ({if_valid, rom_addr} !== {1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL midreset_restart: got v=%b ra=%h want 0 0", if_valid, rom_addr);
      end
      cyc(); #1;
      n_cmp++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0}) begin
         n_bad++;
         $display("FAIL midreset_first: got v=%b pc=%h instr=%h want 1 0 0", if_valid, if_pc, if_instr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_buffered();
      test_redirect_accept();
      test_wrap();
      test_misalign();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
